reel_sequencer: RTL and testbench

- Game controller for the slot machine: sequences the three reels through start → spin → staggered stop → evaluate → show result.
- Owns its own reel-step tick, a single-cycle enable rather than a derived clock, so all logic runs on mclk alone.
- Reel values feed the 7-segment digit path; `win`/`win_valid` feed the result LEDs/scoring.

---
 rtl/slot_pkg.sv | 20 ++
 rtl/tick_gen.sv | 26 ++
 rtl/reel_sequencer.sv | 118 +++++++++++
 tb/tb_reel_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types and helpers for the slot machine game controller.
package slot_pkg;

    localparam int NUM_REELS = 3;
    localparam int SYM_W     = 4;

    typedef logic [SYM_W-1:0] symbol_t;

    typedef enum logic [2:0] {IDLE, SPIN, SETTLE, EVAL, SHOW} state_t;

    // One-subtract wrap; the extra sum bit keeps 15+3 from overflowing at NUM_SYMBOLS=16.
    function automatic symbol_t step_sym(symbol_t v, int inc, int ns);
        logic [SYM_W:0] s;
        s = {1'b0, v} + (SYM_W+1)'(inc);
        if (s >= (SYM_W+1)'(ns))
            s = s - (SYM_W+1)'(ns);
        return s[SYM_W-1:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Single-cycle enable every DIV cycles while en is high; counter parked at 0 otherwise.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/reel_sequencer.sv
// Slot machine game sequencer: start, spin, staggered stop per reel, evaluate, show result.
module reel_sequencer
    import slot_pkg::*;
#(
    parameter int TICK_DIV     = 2_000_000,
    parameter int NUM_SYMBOLS  = 10,
    parameter int SETTLE_TICKS = 3,
    parameter int HOLD_TICKS   = 25
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] reel0,
    output logic [3:0] reel1,
    output logic [3:0] reel2,
    output logic [2:0] spinning,
    output logic       busy,
    output logic       win,
    output logic       win_valid
);

    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    state_t        state;
    symbol_t       reel    [NUM_REELS];
    symbol_t       stepped [NUM_REELS];
    logic [1:0]    target;
    logic [1:0]    lowest;
    logic [2:0]    remaining;
    logic [SW-1:0] settle_cnt;
    logic [HW-1:0] hold_cnt;
    logic          tick;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .mclk  (mclk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .tick  (tick)
    );

    always_comb begin
        for (int i = 0; i < NUM_REELS; i++)
            stepped[i] = step_sym(reel[i], i + 1, NUM_SYMBOLS);
    end

    always_comb begin
        lowest = '0;
        for (int i = NUM_REELS - 1; i >= 0; i--)
            if (spinning[i]) lowest = 2'(i);
    end

    always_comb begin
        remaining         = spinning;
        remaining[target] = 1'b0;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < NUM_REELS; i++) reel[i] <= '0;
            spinning   <= '0;
            target     <= '0;
            settle_cnt <= '0;
            hold_cnt   <= '0;
            busy       <= 1'b0;
            win        <= 1'b0;
            win_valid  <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            // Reels only move while their spinning bit is set, so no state gating is needed.
            if (tick)
                for (int i = 0; i < NUM_REELS; i++)
                    if (spinning[i]) reel[i] <= stepped[i];

            case (state)
                IDLE: if (start) begin
                    state    <= SPIN;
                    spinning <= 3'b111;
                    busy     <= 1'b1;
                    win      <= 1'b0;
                end
                SPIN: if (stop) begin
                    state      <= SETTLE;
                    target     <= lowest;
                    settle_cnt <= SW'(SETTLE_TICKS);
                end
                SETTLE: if (tick) begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt == SW'(1)) begin
                        spinning[target] <= 1'b0;
                        state            <= (remaining != '0) ? SPIN : EVAL;
                    end
                end
                EVAL: begin
                    win       <= (reel[0] == reel[1]) && (reel[1] == reel[2]);
                    win_valid <= 1'b1;
                    hold_cnt  <= HW'(HOLD_TICKS);
                    state     <= SHOW;
                end
                SHOW: if (tick) begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == HW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign reel0 = reel[0];
    assign reel1 = reel[1];
    assign reel2 = reel[2];

endmodule

// File: tb/tb_reel_sequencer.sv
// Bench for reel_sequencer: two instances (10 and 4 symbols) against a cycle model plus literal checkpoints.
module tb_reel_sequencer;

    localparam int DIV = 4;
    localparam int ST  = 2;
    localparam int HT  = 3;
    localparam int NSA = 10;
    localparam int NSB = 4;

    logic       mclk  = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] stop  = '0;
    logic [3:0] r0 [2];
    logic [3:0] r1 [2];
    logic [3:0] r2 [2];
    logic [2:0] spn [2];
    logic       busy [2];
    logic       win [2];
    logic       wv [2];

    int tests = 0;
    int fails = 0;

    always #5 mclk = ~mclk;

    reel_sequencer #(.TICK_DIV(DIV), .NUM_SYMBOLS(NSA), .SETTLE_TICKS(ST), .HOLD_TICKS(HT)) dut_a (
        .mclk(mclk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]),
        .reel0(r0[0]), .reel1(r1[0]), .reel2(r2[0]), .spinning(spn[0]),
        .busy(busy[0]), .win(win[0]), .win_valid(wv[0])
    );

    reel_sequencer #(.TICK_DIV(DIV), .NUM_SYMBOLS(NSB), .SETTLE_TICKS(ST), .HOLD_TICKS(HT)) dut_b (
        .mclk(mclk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]),
        .reel0(r0[1]), .reel1(r1[1]), .reel2(r2[1]), .spinning(spn[1]),
        .busy(busy[1]), .win(win[1]), .win_valid(wv[1])
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: phase 0=idle 1=spin 2=settle 3=eval 4=show; age counts cycles since the start.
    int       mst [2];
    int       mage [2];
    int       mreel [2][3];
    int       msettle [2];
    int       mhold [2];
    int       mtgt [2];
    bit [2:0] mspin [2];
    bit       mwin [2];
    bit       mwv [2];

    function automatic int ns_of(input int d);
        return (d == 0) ? NSA : NSB;
    endfunction

    task automatic model_reset(input int d);
        mst[d] = 0; mage[d] = 0; msettle[d] = 0; mhold[d] = 0; mtgt[d] = 0;
        mspin[d] = '0; mwin[d] = 0; mwv[d] = 0;
        for (int i = 0; i < 3; i++) mreel[d][i] = 0;
    endtask

    task automatic model_step(input int d);
        bit tk;
        tk = (mst[d] != 0) && (mage[d] % DIV == DIV - 1);
        if (mst[d] != 0) mage[d]++;
        mwv[d] = 0;
        if (tk)
            for (int i = 0; i < 3; i++)
                if (mspin[d][i]) mreel[d][i] = (mreel[d][i] + i + 1) % ns_of(d);
        case (mst[d])
            0: if (start[d]) begin
                mst[d] = 1; mspin[d] = 3'b111; mwin[d] = 0; mage[d] = 0;
            end
            1: if (stop[d]) begin
                for (int i = 2; i >= 0; i--) if (mspin[d][i]) mtgt[d] = i;
                msettle[d] = ST;
                mst[d] = 2;
            end
            2: if (tk) begin
                msettle[d]--;
                if (msettle[d] == 0) begin
                    mspin[d][mtgt[d]] = 1'b0;
                    mst[d] = (mspin[d] != 0) ? 1 : 3;
                end
            end
            3: begin
                mwin[d] = (mreel[d][0] == mreel[d][1]) && (mreel[d][1] == mreel[d][2]);
                mwv[d] = 1;
                mhold[d] = HT;
                mst[d] = 4;
            end
            default: if (tk) begin
                mhold[d]--;
                if (mhold[d] == 0) mst[d] = 0;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge mclk);
            for (int d = 0; d < 2; d++)
                if (!rst_n) model_reset(d); else model_step(d);
            #2;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d_reel0", d), r0[d], mreel[d][0]);
                check($sformatf("dut%0d_reel1", d), r1[d], mreel[d][1]);
                check($sformatf("dut%0d_reel2", d), r2[d], mreel[d][2]);
                check($sformatf("dut%0d_spinning", d), spn[d], mspin[d]);
                check($sformatf("dut%0d_busy", d), busy[d], (mst[d] != 0) ? 1 : 0);
                check($sformatf("dut%0d_win", d), win[d], mwin[d]);
                check($sformatf("dut%0d_win_valid", d), wv[d], mwv[d]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // Called on a negedge; the pulse is sampled on the following posedge.
    task automatic pulse(input int d, input bit s, input bit p);
        start[d] = s;
        stop[d]  = p;
        @(negedge mclk);
        start[d] = 1'b0;
        stop[d]  = 1'b0;
    endtask

    task automatic check_reels(input string tag, input int d, input int a, input int b, input int c);
        check({tag, "_r0"}, r0[d], a);
        check({tag, "_r1"}, r1[d], b);
        check({tag, "_r2"}, r2[d], c);
    endtask

    task automatic wait_wv(input string tag, input int d);
        int n;
        n = 0;
        while (!wv[d] && n < 40) begin
            @(negedge mclk);
            n++;
        end
        check({tag, "_win_valid_seen"}, wv[d], 1);
    endtask

    initial begin
        cyc(2);
        check_reels("rst", 0, 0, 0, 0);
        check("rst_spinning", spn[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_win_valid", wv[0], 0);
        rst_n = 1'b1;
        cyc(1);

        // Stop in IDLE does nothing; then start and stop together: start wins.
        pulse(0, 1'b0, 1'b1);
        cyc(2);
        check("idle_stop_busy", busy[0], 0);
        pulse(0, 1'b1, 1'b1);
        cyc(3);
        check_reels("pre_tick", 0, 0, 0, 0);
        cyc(1);
        check_reels("tick1", 0, 1, 2, 3);
        cyc(4);
        check_reels("tick2", 0, 2, 4, 6);
        cyc(4);
        check_reels("tick3", 0, 3, 6, 9);
        cyc(4);
        check_reels("tick4", 0, 4, 8, 2);
        check("tick4_spinning", spn[0], 3'b111);

        // Stop reel0 at 4; a second stop in SETTLE must be dropped.
        pulse(0, 1'b0, 1'b1);
        pulse(0, 1'b0, 1'b1);
        cyc(2);
        check("settle1_r0", r0[0], 5);
        check("settle1_spinning", spn[0], 3'b111);
        cyc(4);
        check_reels("lock0", 0, 6, 2, 8);
        check("lock0_spinning", spn[0], 3'b110);

        pulse(0, 1'b0, 1'b1);
        cyc(7);
        check("lock1_r1", r1[0], 6);
        check("lock1_spinning", spn[0], 3'b100);
        pulse(0, 1'b0, 1'b1);
        wait_wv("lose", 0);
        check("lose_win", win[0], 0);
        check_reels("lose", 0, 6, 6, 0);
        pulse(0, 1'b1, 1'b0);
        cyc(9);
        check("show_busy", busy[0], 1);
        cyc(1);
        check("show_end_busy", busy[0], 0);

        // Reset while reel1 settles.
        cyc(1);
        pulse(0, 1'b1, 1'b0);
        pulse(0, 1'b0, 1'b1);
        cyc(7);
        pulse(0, 1'b0, 1'b1);
        cyc(1);
        rst_n = 1'b0;
        #1;
        check_reels("async_rst", 0, 0, 0, 0);
        check("async_rst_spinning", spn[0], 0);
        check("async_rst_busy", busy[0], 0);
        @(negedge mclk);
        rst_n = 1'b1;
        pulse(0, 1'b1, 1'b0);
        cyc(4);
        check_reels("clean_tick1", 0, 1, 2, 3);

        // Four-symbol instance: all reels lock on 0 for a win.
        pulse(1, 1'b1, 1'b0);
        cyc(9);
        pulse(1, 1'b0, 1'b1);
        cyc(7);
        check("b_lock0_r0", r0[1], 0);
        check("b_lock0_spinning", spn[1], 3'b110);
        pulse(1, 1'b0, 1'b1);
        cyc(7);
        check("b_lock1_r1", r1[1], 0);
        check("b_lock1_spinning", spn[1], 3'b100);
        pulse(1, 1'b0, 1'b1);
        wait_wv("b_win", 1);
        check("b_win", win[1], 1);
        check_reels("b_win", 1, 0, 0, 0);
        cyc(1);
        check("b_win_valid_single", wv[1], 0);
        cyc(9);
        check("b_show_busy", busy[1], 1);
        cyc(1);
        check("b_idle_busy", busy[1], 0);
        cyc(3);
        check("b_idle_win_held", win[1], 1);
        pulse(1, 1'b1, 1'b0);
        check("b_restart_win", win[1], 0);
        check("b_restart_spinning", spn[1], 3'b111);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
